// File: rtl/axil_pkg.sv
// Shared AXI-Lite master definitions: FSM states, response codes and width defaults.
package axil_pkg;

  localparam int ADDR_W_DEF         = 4;
  localparam int DATA_W_DEF         = 32;
  localparam int TIMEOUT_CYCLES_DEF = 256;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } axil_state_e;

endpackage

// File: rtl/axil_master.sv
// AXI-Lite initiator: one outstanding command turned into an AXI-Lite read or write.
// Define AXIL_MASTER_TIMEOUT_EN to add the sticky response-wait watchdog (timeout_err).
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// WR_AW_W | write address/data offered, each handshake tracked separately
// WR_B    | waiting for write response, bready high
// RD_AR   | read address offered
// RD_R    | waiting for read data, rready high
// RSP     | completion held on rsp_* until rsp_ready
module axil_master
  import axil_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
`ifdef AXIL_MASTER_TIMEOUT_EN
  output logic                timeout_err,
`endif
  output logic                busy
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("axil_master: DATA_W must be 32");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("axil_master: TIMEOUT_CYCLES must be at least 2");
  end

  axil_state_e         state, state_nxt;
  logic                aw_done, aw_done_nxt;
  logic                w_done, w_done_nxt;
  logic                rdy_en;
  logic [ADDR_W-1:0]   awaddr_nxt, araddr_nxt;
  logic [DATA_W-1:0]   wdata_nxt, rdata_nxt;
  logic [DATA_W/8-1:0] wstrb_nxt;
  logic                awvalid_nxt, wvalid_nxt, arvalid_nxt;
  logic                bready_nxt, rready_nxt;
  logic                rsp_valid_nxt, rsp_write_nxt;
  logic [1:0]          resp_nxt;
  logic                aw_hs, w_hs;

  // rdy_en keeps cmd_ready low through reset and until the first clock after release
  assign cmd_ready = rdy_en && (state == IDLE);
  assign aw_hs     = m_axi_awvalid && m_axi_awready;
  assign w_hs      = m_axi_wvalid && m_axi_wready;

  always_comb begin
    state_nxt     = state;
    aw_done_nxt   = aw_done;
    w_done_nxt    = w_done;
    awaddr_nxt    = m_axi_awaddr;
    awvalid_nxt   = m_axi_awvalid;
    wdata_nxt     = m_axi_wdata;
    wstrb_nxt     = m_axi_wstrb;
    wvalid_nxt    = m_axi_wvalid;
    bready_nxt    = m_axi_bready;
    araddr_nxt    = m_axi_araddr;
    arvalid_nxt   = m_axi_arvalid;
    rready_nxt    = m_axi_rready;
    rsp_valid_nxt = rsp_valid;
    rsp_write_nxt = rsp_write;
    rdata_nxt     = rsp_rdata;
    resp_nxt      = rsp_resp;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_write) begin
            awaddr_nxt  = cmd_addr;
            wdata_nxt   = cmd_wdata;
            wstrb_nxt   = cmd_wstrb;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            state_nxt   = WR_AW_W;
          end else begin
            araddr_nxt  = cmd_addr;
            arvalid_nxt = 1'b1;
            state_nxt   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        aw_done_nxt = aw_done | aw_hs;
        w_done_nxt  = w_done | w_hs;
        if (aw_hs) awvalid_nxt = 1'b0;
        if (w_hs)  wvalid_nxt  = 1'b0;
        if (aw_done_nxt && w_done_nxt) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_B;
        end
      end
      WR_B: begin
        if (m_axi_bvalid && m_axi_bready) begin
          bready_nxt    = 1'b0;
          resp_nxt      = m_axi_bresp;
          rdata_nxt     = '0;
          rsp_write_nxt = 1'b1;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RSP;
        end
      end
      RD_AR: begin
        if (m_axi_arvalid && m_axi_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_R;
        end
      end
      RD_R: begin
        if (m_axi_rvalid && m_axi_rready) begin
          rready_nxt    = 1'b0;
          resp_nxt      = m_axi_rresp;
          rdata_nxt     = m_axi_rdata;
          rsp_write_nxt = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rdy_en        <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      rdy_en        <= 1'b1;
      aw_done       <= aw_done_nxt;
      w_done        <= w_done_nxt;
      m_axi_awaddr  <= awaddr_nxt;
      m_axi_awvalid <= awvalid_nxt;
      m_axi_wdata   <= wdata_nxt;
      m_axi_wstrb   <= wstrb_nxt;
      m_axi_wvalid  <= wvalid_nxt;
      m_axi_bready  <= bready_nxt;
      m_axi_araddr  <= araddr_nxt;
      m_axi_arvalid <= arvalid_nxt;
      m_axi_rready  <= rready_nxt;
      rsp_valid     <= rsp_valid_nxt;
      rsp_write     <= rsp_write_nxt;
      rsp_rdata     <= rdata_nxt;
      rsp_resp      <= resp_nxt;
      busy          <= (state_nxt != IDLE);
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES);
  // loaded two short so the flag is visible in the TIMEOUT_CYCLES-th waiting cycle
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 2);

  logic [TMO_W-1:0] tmo_cnt;
  logic             wait_st;

  assign wait_st = (state == WR_AW_W) || (state == WR_B) ||
                   (state == RD_AR) || (state == RD_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= TMO_LOAD;
      timeout_err <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        tmo_cnt <= TMO_LOAD;
      end else if (wait_st && (tmo_cnt != '0)) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (wait_st && (state_nxt == state) && (tmo_cnt == '0)) begin
        timeout_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axil_master.sv
// Self-checking bench for axil_master: a configurable-latency AXI-Lite slave with a word memory,
// a byte-lane reference memory, and a protocol monitor on the AW/W/AR channels.
`timescale 1ns/1ps
module tb_axil_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  m_axi_awaddr, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic [31:0] m_axi_rdata;
  logic        busy;
`ifdef AXIL_MASTER_TIMEOUT_EN
  logic        timeout_err;
`endif

  axil_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
`ifdef AXIL_MASTER_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // slave configuration and state
  int          aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
  logic [1:0]  b_resp_k = 2'b00, r_resp_k = 2'b00;
  bit          r_ovr = 1'b0;
  logic [31:0] r_ovr_data = '0;
  bit          inj_b = 1'b0, inj_r = 1'b0;
  logic        s_awready = 1'b0, s_wready = 1'b0, s_arready = 1'b0;
  logic        s_bvalid = 1'b0, s_rvalid = 1'b0;
  logic [1:0]  s_bresp = '0, s_rresp = '0;
  logic [31:0] s_rdata = '0;
  bit          aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, b_win_n = 0;
  logic [3:0]  sw_addr = '0, sw_strb = '0, sr_addr = '0;
  logic [31:0] sw_data = '0;
  logic [31:0] slv_mem [0:3] = '{default: 32'h0};
  logic [31:0] ref_mem [0:3] = '{default: 32'h0};

  bit tr_aw [0:63];
  bit tr_w  [0:63];
  bit tr_ar [0:63];
  bit tr_to [0:63];

  assign m_axi_awready = s_awready;
  assign m_axi_wready  = s_wready;
  assign m_axi_arready = s_arready;
  assign m_axi_bvalid  = s_bvalid | inj_b;
  assign m_axi_bresp   = s_bresp;
  assign m_axi_rvalid  = s_rvalid | inj_r;
  assign m_axi_rresp   = s_rresp;
  assign m_axi_rdata   = s_rdata;

  // slave: decides readies/valids at negedge so they are stable across the next posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      s_awready = 0; s_wready = 0; s_arready = 0; s_bvalid = 0; s_rvalid = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      if (b_fire) begin
        s_bvalid = 0; b_fire = 0;
      end else if (!s_bvalid && aw_got && w_got) begin
        if (b_cnt >= b_lat) begin
          for (int i = 0; i < 4; i++)
            if (sw_strb[i]) slv_mem[sw_addr[3:2]][8*i +: 8] = sw_data[8*i +: 8];
          s_bvalid = 1; s_bresp = b_resp_k; aw_got = 0; w_got = 0; b_cnt = 0;
        end else b_cnt++;
      end
      if (s_bvalid && m_axi_bready) b_fire = 1;

      if (r_fire) begin
        s_rvalid = 0; r_fire = 0;
      end else if (!s_rvalid && ar_got) begin
        if (r_cnt >= r_lat) begin
          s_rdata = r_ovr ? r_ovr_data : slv_mem[sr_addr[3:2]];
          s_rvalid = 1; s_rresp = r_resp_k; ar_got = 0; r_cnt = 0;
        end else r_cnt++;
      end
      if (s_rvalid && m_axi_rready) r_fire = 1;

      s_awready = 0;
      if (m_axi_awvalid && !aw_got) begin
        if (aw_cnt >= aw_lat) begin
          s_awready = 1; aw_got = 1; sw_addr = m_axi_awaddr; aw_cnt = 0; aw_hs_n++;
        end else aw_cnt++;
      end
      s_wready = 0;
      if (m_axi_wvalid && !w_got) begin
        if (w_cnt >= w_lat) begin
          s_wready = 1; w_got = 1; sw_data = m_axi_wdata; sw_strb = m_axi_wstrb; w_cnt = 0; w_hs_n++;
        end else w_cnt++;
      end
      s_arready = 0;
      if (m_axi_arvalid && !ar_got) begin
        if (ar_cnt >= ar_lat) begin
          s_arready = 1; ar_got = 1; sr_addr = m_axi_araddr; ar_cnt = 0; ar_hs_n++;
        end else ar_cnt++;
      end
    end
  end

  // protocol monitor: a VALID without handshake must persist with a stable payload
  logic        p_aw = 0, p_w = 0, p_ar = 0, p_bready = 0;
  logic [3:0]  p_awaddr = '0, p_araddr = '0, p_wstrb = '0;
  logic [31:0] p_wdata = '0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      p_aw = 0; p_w = 0; p_ar = 0; p_bready = 0;
    end else begin
      if (p_aw && !m_axi_awready) begin
        total++;
        if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== p_awaddr) begin
          bad++; $display("FAIL aw_stable: valid=%b addr=%h required valid=1 addr=%h", m_axi_awvalid, m_axi_awaddr, p_awaddr);
        end
      end
      if (p_w && !m_axi_wready) begin
        total++;
        if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== p_wdata || m_axi_wstrb !== p_wstrb) begin
          bad++; $display("FAIL w_stable: valid=%b data=%h strb=%h required valid=1 data=%h strb=%h", m_axi_wvalid, m_axi_wdata, m_axi_wstrb, p_wdata, p_wstrb);
        end
      end
      if (p_ar && !m_axi_arready) begin
        total++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== p_araddr) begin
          bad++; $display("FAIL ar_stable: valid=%b addr=%h required valid=1 addr=%h", m_axi_arvalid, m_axi_araddr, p_araddr);
        end
      end
      if (m_axi_bready && !p_bready) b_win_n++;
      p_aw = m_axi_awvalid; p_awaddr = m_axi_awaddr;
      p_w = m_axi_wvalid; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
      p_ar = m_axi_arvalid; p_araddr = m_axi_araddr;
      p_bready = m_axi_bready;
    end
  end

  function automatic void ref_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) ref_mem[a[3:2]][8*i +: 8] = d[8*i +: 8];
  endfunction

  task automatic slave_cfg(input int aw, input int w, input int ar, input int b, input int r,
                           input logic [1:0] br, input logic [1:0] rr);
    aw_lat = aw; w_lat = w; ar_lat = ar; b_lat = b; r_lat = r; b_resp_k = br; r_resp_k = rr;
  endtask

  // issue one command from a negedge; return at the negedge where rsp_valid is first seen
  task automatic do_txn(input bit wr, input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                        output int lat, output bit ok, output logic [31:0] rd, output logic [1:0] rs,
                        output bit rw);
    int n;
    ok = 0; lat = 0; rd = '0; rs = '0; rw = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      total++; bad++; cmd_valid = 0;
      $display("FAIL accept_wait: cmd_ready=%b after %0d cycles required 1", cmd_ready, n);
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 4'($urandom);
    cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    for (int k = 0; k < 64; k++) begin tr_aw[k] = 0; tr_w[k] = 0; tr_ar[k] = 0; tr_to[k] = 0; end
    for (int k = 1; k < 300; k++) begin
      @(negedge clk);
      if (k < 64) begin
        tr_aw[k] = m_axi_awvalid; tr_w[k] = m_axi_wvalid; tr_ar[k] = m_axi_arvalid;
`ifdef AXIL_MASTER_TIMEOUT_EN
        tr_to[k] = timeout_err;
`endif
      end
      if (rsp_valid) begin
        lat = k; ok = 1; rd = rsp_rdata; rs = rsp_resp; rw = rsp_write;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL rsp_wait: rsp_valid=%b after 300 cycles required 1", rsp_valid);
    end
  endtask

  task automatic consume_rsp(input int hold);
    repeat (hold) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid, cmd_ready, busy} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl: aw=%b w=%b ar=%b b=%b r=%b rsp=%b cmd_rdy=%b busy=%b required all 0",
                      m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid, cmd_ready, busy);
    end
    total++;
    if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_araddr, rsp_rdata, rsp_resp, rsp_write} !== 79'h0) begin
      bad++; $display("FAIL reset_data: awaddr=%h wdata=%h wstrb=%h araddr=%h rdata=%h resp=%h wr=%b required 0",
                      m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_araddr, rsp_rdata, rsp_resp, rsp_write);
    end
    rst_n = 1;
    @(posedge clk); @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_release: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_read();
    int lat; bit ok, rw; logic [31:0] rd; logic [1:0] rs;
    slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00);
    do_txn(1, 4'h4, 32'hDEADBEEF, 4'hF, lat, ok, rd, rs, rw);
    ref_write(4'h4, 32'hDEADBEEF, 4'hF);
    if (ok) begin
      total++;
      if (tr_aw[1] !== 1'b1 || tr_w[1] !== 1'b1) begin
        bad++; $display("FAIL wr_valid_c1: awvalid=%b wvalid=%b required 1/1", tr_aw[1], tr_w[1]);
      end
      total++;
      if (lat !== 3 || rw !== 1'b1 || rs !== 2'b00 || rd !== 32'h0) begin
        bad++; $display("FAIL wr_rsp: lat=%0d write=%b resp=%b rdata=%h required 3/1/00/0", lat, rw, rs, rd);
      end
    end
    consume_rsp(0);
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL wr_rsp_drop: rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
    end
    do_txn(0, 4'h4, 32'h0, 4'h0, lat, ok, rd, rs, rw);
    if (ok) begin
      total++;
      if (tr_ar[1] !== 1'b1 || lat !== 3) begin
        bad++; $display("FAIL rd_timing: arvalid_c1=%b lat=%0d required 1/3", tr_ar[1], lat);
      end
      total++;
      if (rd !== 32'hDEADBEEF || rs !== 2'b00 || rw !== 1'b0) begin
        bad++; $display("FAIL rd_rsp: rdata=%h resp=%b write=%b required deadbeef/00/0", rd, rs, rw);
      end
    end
    consume_rsp(0);
  endtask

  task automatic test_delayed_aw();
    int lat; bit ok, rw; logic [31:0] rd; logic [1:0] rs;
    int aw0, w0, b0;
    slave_cfg(3, 0, 0, 0, 0, 2'b00, 2'b00);
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_win_n;
    do_txn(1, 4'h8, 32'hA5A55A5A, 4'hF, lat, ok, rd, rs, rw);
    ref_write(4'h8, 32'hA5A55A5A, 4'hF);
    if (ok) begin
      total++;
      if (tr_w[1] !== 1'b1 || tr_w[2] !== 1'b0) begin
        bad++; $display("FAIL dly_wvalid: c1=%b c2=%b required 1/0", tr_w[1], tr_w[2]);
      end
      total++;
      if ({tr_aw[1], tr_aw[2], tr_aw[3], tr_aw[4], tr_aw[5]} !== 5'b11110) begin
        bad++; $display("FAIL dly_awvalid: c1..c5=%b%b%b%b%b required 11110", tr_aw[1], tr_aw[2], tr_aw[3], tr_aw[4], tr_aw[5]);
      end
      total++;
      if (lat !== 6 || rw !== 1'b1 || rs !== 2'b00) begin
        bad++; $display("FAIL dly_rsp: lat=%0d write=%b resp=%b required 6/1/00", lat, rw, rs);
      end
    end
    consume_rsp(0);
    total++;
    if (aw_hs_n - aw0 !== 1 || w_hs_n - w0 !== 1 || b_win_n - b0 !== 1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL dly_counts: aw_hs=%0d w_hs=%0d b_windows=%0d rsp_valid=%b required 1/1/1/0",
                      aw_hs_n - aw0, w_hs_n - w0, b_win_n - b0, rsp_valid);
    end
  endtask

  task automatic test_error_read();
    int lat; bit ok, rw; logic [31:0] rd; logic [1:0] rs;
    slave_cfg(0, 0, 0, 0, 1, 2'b00, 2'b10);
    r_ovr = 1; r_ovr_data = 32'h12345678;
    do_txn(0, 4'hC, 32'h0, 4'h0, lat, ok, rd, rs, rw);
    if (ok) begin
      total++;
      if (rd !== 32'h12345678 || rs !== 2'b10 || rw !== 1'b0) begin
        bad++; $display("FAIL err_rsp: rdata=%h resp=%b write=%b required 12345678/10/0", rd, rs, rw);
      end
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_resp !== 2'b10 || cmd_ready !== 1'b0) begin
          bad++; $display("FAIL err_hold%0d: rsp_valid=%b rdata=%h resp=%b cmd_ready=%b required 1/12345678/10/0",
                          i, rsp_valid, rsp_rdata, rsp_resp, cmd_ready);
        end
      end
    end
    consume_rsp(0);
    r_ovr = 0;
  endtask

  task automatic test_stray_resp();
    inj_b = 1; inj_r = 1;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || m_axi_bready !== 1'b0 || m_axi_rready !== 1'b0) begin
      bad++; $display("FAIL stray_resp: busy=%b rsp_valid=%b cmd_ready=%b bready=%b rready=%b required 0/0/1/0/0",
                      busy, rsp_valid, cmd_ready, m_axi_bready, m_axi_rready);
    end
    inj_b = 0; inj_r = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat; bit ok, rw; logic [31:0] rd; logic [1:0] rs;
    bit wr; logic [3:0] a, s; logic [31:0] d; logic [1:0] br, rr;
    logic [31:0] exp_d; int aw0, w0, ar0;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom); a = 4'($urandom); d = $urandom; s = 4'($urandom);
      br = 2'($urandom); rr = 2'($urandom);
      slave_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), br, rr);
      aw0 = aw_hs_n; w0 = w_hs_n; ar0 = ar_hs_n;
      exp_d = wr ? 32'h0 : ref_mem[a[3:2]];
      do_txn(wr, a, d, s, lat, ok, rd, rs, rw);
      if (wr) ref_write(a, d, s);
      if (ok) begin
        total++;
        if (rw !== wr || rd !== exp_d || rs !== (wr ? br : rr)) begin
          bad++; $display("FAIL rand%0d_rsp: write=%b rdata=%h resp=%b required %b/%h/%b",
                          t, rw, rd, rs, wr, exp_d, wr ? br : rr);
        end
      end
      consume_rsp($urandom_range(0, 2));
      total++;
      if (aw_hs_n - aw0 !== int'(wr) || w_hs_n - w0 !== int'(wr) || ar_hs_n - ar0 !== int'(!wr) || rsp_valid !== 1'b0) begin
        bad++; $display("FAIL rand%0d_hs: aw=%0d w=%0d ar=%0d rsp_valid=%b required %0d/%0d/%0d/0",
                        t, aw_hs_n - aw0, w_hs_n - w0, ar_hs_n - ar0, rsp_valid, int'(wr), int'(wr), int'(!wr));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    slave_cfg(0, 0, 0, 10, 0, 2'b00, 2'b00);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h0; cmd_wdata = 32'hFFFFFFFF; cmd_wstrb = 4'hF;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 0;
    while (m_axi_bready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (m_axi_bready !== 1'b1) begin
      bad++; $display("FAIL mid_reach_wr_b: bready=%b required 1", m_axi_bready);
    end
    #2 rst_n = 0;
    #1;
    total++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid} !== 6'b0) begin
      bad++; $display("FAIL mid_reset_async: aw=%b w=%b ar=%b b=%b r=%b rsp=%b required all 0",
                      m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00);
    @(posedge clk); @(negedge clk);
    total++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL mid_release: busy=%b cmd_ready=%b required 0/1", busy, cmd_ready);
    end
  endtask

  task automatic test_readback_after_reset();
    int lat; bit ok, rw; logic [31:0] rd; logic [1:0] rs;
    do_txn(0, 4'h0, 32'h0, 4'h0, lat, ok, rd, rs, rw);
    if (ok) begin
      total++;
      if (rd !== ref_mem[0] || rs !== 2'b00) begin
        bad++; $display("FAIL lost_write: rdata=%h resp=%b required %h/00", rd, rs, ref_mem[0]);
      end
    end
    consume_rsp(0);
  endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int lat; bit ok, rw; logic [31:0] rd; logic [1:0] rs;
    slave_cfg(0, 0, 20, 0, 0, 2'b00, 2'b00);
    do_txn(0, 4'h8, 32'h0, 4'h0, lat, ok, rd, rs, rw);
    if (ok) begin
      total++;
      if (tr_to[15] !== 1'b0 || tr_to[16] !== 1'b1) begin
        bad++; $display("FAIL timeout_edge: c15=%b c16=%b required 0/1", tr_to[15], tr_to[16]);
      end
      total++;
      if (rd !== ref_mem[2] || rs !== 2'b00 || lat !== 23) begin
        bad++; $display("FAIL timeout_read: rdata=%h resp=%b lat=%0d required %h/00/23", rd, rs, lat, ref_mem[2]);
      end
    end
    consume_rsp(0);
    repeat (3) @(negedge clk);
    total++;
    if (timeout_err !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky: timeout_err=%b required 1", timeout_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_delayed_aw();
    test_error_read();
    test_stray_resp();
    test_random();
    test_reset_mid();
    test_readback_after_reset();
`ifdef AXIL_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/axil_master.md
Name: axil_master

Overview:
- AXI-Lite initiator. Converts a simple single-outstanding command/response interface into AXI-Lite read and write transactions.
- Drives the slave port of the register block in the top-level wrapper; used by a bench sequencer or an on-chip controller.
- One transaction in flight; strict in-order completion.

Parameters:
- ADDR_W, 4, AXI address width (byte address).
- DATA_W, 32, AXI data width; must be 32 (assertion).
- TIMEOUT_CYCLES, 256, response-wait limit used only by the optional timeout feature; must be ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  completion available.
- rsp_ready  in  1  completion consumed.
- rsp_write  out  1  completed op was a write.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  AXI BRESP/RRESP of the completed op.
- m_axi_awaddr, awvalid (out); awready (in): AW channel, ADDR_W/1/1.
- m_axi_wdata, wstrb, wvalid (out); wready (in): W channel, DATA_W/DATA_W/8/1/1.
- m_axi_bresp (in, 2), bvalid (in, 1), bready (out, 1): B channel.
- m_axi_araddr, arvalid (out); arready (in): AR channel.
- m_axi_rdata (in, DATA_W), rresp (in, 2), rvalid (in, 1), rready (out, 1): R channel.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all valid, ready, and busy outputs are 0; all address, data, and resp outputs are 0; state is IDLE. cmd_ready goes high in the first cycle after reset release.
- All outputs are registered except cmd_ready, which is 1 iff state==IDLE.
- States and transitions:
  - IDLE: on cmd_valid&&cmd_ready, capture the command.
    - Write → WR_AW_W; awvalid and wvalid both rise the next cycle with the captured addr, data, and strb.
    - Read → RD_AR; arvalid rises the next cycle.
  - WR_AW_W: awvalid drops the cycle after the AW handshake; wvalid drops the cycle after the W handshake. The two handshakes are tracked independently (aw_done, w_done), in either order or the same cycle. When both are done → WR_B, with bready=1.
  - WR_B: on bvalid&&bready, bready=0, latch bresp, → RSP.
  - RD_AR: on the AR handshake, arvalid=0, rready=1, → RD_R.
  - RD_R: on rvalid&&rready, rready=0, latch rdata and rresp, → RSP.
  - RSP: rsp_valid=1, stable until rsp_ready. In the handshake cycle → IDLE; rsp_valid=0 next cycle.
- Minimum latency with an always-ready slave, counted from command acceptance (cycle 0):
  - Write: AW/W valid at cycle 1; B handshake at cycle 2 or later; rsp_valid the cycle after the B handshake.
  - Read: arvalid at cycle 1; rsp_valid the cycle after the R handshake.
- AXI rules:
  - No VALID ever deasserts before its handshake. Addr, data, and strb are stable while VALID is high.
  - bready and rready are asserted only in WR_B and RD_R. A bvalid or rvalid in any other state is ignored and must not change state.
- cmd_* inputs are sampled only on acceptance; later changes have no effect.
- rresp and bresp are passed through unmodified, including SLVERR and DECERR.
- Reset mid-transaction: all VALID and READY outputs drop asynchronously and the in-flight command is lost. The system resets the slave together with the master.

Optional Feature:
- Macro: AXIL_MASTER_TIMEOUT_EN.
- With it defined:
  - A counter runs in WR_AW_W, WR_B, RD_AR, and RD_R and clears on every state change.
  - When it reaches TIMEOUT_CYCLES, a sticky output timeout_err (1 bit, reset 0) is set. It clears only on reset.
  - The FSM keeps waiting, so the protocol stays legal.
- Without it: the timeout_err port and the counter do not exist.

Decomposition:
- Package axil_pkg holds:
  - the state enum (IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP);
  - the response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the width defaults.
- No sub-module; the timeout counter is inline.

Test Plan:
- Write: addr 4'h4, data 32'hDEADBEEF, strb 4'hF, slave always ready → awvalid and wvalid at cycle 1; rsp_valid at cycle 3 with rsp_write=1, rsp_resp=2'b00.
- Read back from 4'h4 → rsp_rdata=32'hDEADBEEF, rsp_resp=2'b00, rsp_write=0.
- Write with awready delayed 3 cycles and wready immediate → wvalid drops after cycle 1, awvalid holds until its handshake, exactly one bready window, single response.
- Slave returns rresp=2'b10 with rdata 32'h12345678 → rsp_resp=2'b10, rsp_rdata=32'h12345678; with rsp_ready held low 5 cycles, rsp_valid and data stay stable and cmd_ready=0 throughout.
- Assert rst_n low while in WR_B → all VALID/READY outputs are 0 immediately; after release, busy=0 and cmd_ready=1.
- With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold arready for 20 cycles → timeout_err=1 at cycle 16 of RD_AR; the read then completes normally and timeout_err stays 1.
